// File: rtl/ast_arb_pkg.sv
// Shared types and the round-robin selection helper for the Avalon-ST packet arbiter.
// rr_pick scans from the pointer upward, wrapping, so the pointer position has top priority.
package ast_arb_pkg;

    localparam int MAX_SRC = 16;
    localparam int MAX_SEL = 4;

    typedef enum logic {ARB_S, XFER_S} arb_state_t;

    typedef struct packed {
        logic               found;
        logic [MAX_SEL-1:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                         input logic [MAX_SEL-1:0] ptr,
                                         input int                 n);
        rr_pick_t           pick;
        int                 k;
        logic [MAX_SEL-1:0] k_idx;
        pick = '0;
        for (int off = 0; off < MAX_SRC; off++) begin
            k = int'(ptr) + off;
            if (k >= n) k = k - n;
            k_idx = k[MAX_SEL-1:0];
            if (off < n && !pick.found && req[k_idx]) begin
                pick.found = 1'b1;
                pick.idx   = k_idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: request vector plus priority pointer in,
// one-hot grant and encoded index out. An all-zero one-hot means nobody requested.
module rr_arbiter #(
    parameter int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant_onehot,
    output logic [SW-1:0] grant_idx
);
    import ast_arb_pkg::*;

    rr_pick_t pick;

    always_comb begin
        pick = rr_pick(MAX_SRC'(req), MAX_SEL'(ptr), N);
        grant_idx = SW'(pick.idx);
        for (int i = 0; i < N; i++) begin
            grant_onehot[i] = pick.found && (pick.idx == MAX_SEL'(i));
        end
    end

endmodule

// File: rtl/ast_packet_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC Avalon-ST sinks onto one source.
// Grant is locked from SOP to EOP; the datapath is a pure mux with no buffering.
module ast_packet_arbiter #(
    parameter int  AST_DWIDTH    = 64,
    parameter int  CHANNEL_WIDTH = 1,
    parameter int  NUM_SRC       = 4,
    localparam int EMPTY_WIDTH   = $clog2(AST_DWIDTH/8),
    localparam int SEL_WIDTH     = $clog2(NUM_SRC)
) (
    input  logic                             clk_i,
    input  logic                             srst_i,
    input  logic [NUM_SRC*AST_DWIDTH-1:0]    snk_data_i,
    input  logic [NUM_SRC*EMPTY_WIDTH-1:0]   snk_empty_i,
    input  logic [NUM_SRC*CHANNEL_WIDTH-1:0] snk_channel_i,
    input  logic [NUM_SRC-1:0]               snk_sop_i,
    input  logic [NUM_SRC-1:0]               snk_eop_i,
    input  logic [NUM_SRC-1:0]               snk_valid_i,
    output logic [NUM_SRC-1:0]               snk_ready_o,
    output logic [AST_DWIDTH-1:0]            src_data_o,
    output logic [EMPTY_WIDTH-1:0]           src_empty_o,
    output logic [CHANNEL_WIDTH-1:0]         src_channel_o,
    output logic                             src_sop_o,
    output logic                             src_eop_o,
    output logic                             src_valid_o,
    input  logic                             src_ready_i,
    input  logic [NUM_SRC-1:0]               port_en_i,
    output logic [SEL_WIDTH-1:0]             grant_o,
    output logic                             busy_o,
    output logic                             err_o
);
    import ast_arb_pkg::*;

    arb_state_t           state;
    logic [SEL_WIDTH-1:0] grant_q;
    logic [SEL_WIDTH-1:0] ptr_q;
    logic [NUM_SRC-1:0]   req;
    logic [NUM_SRC-1:0]   flush;
    logic [NUM_SRC-1:0]   arb_onehot;
    logic [SEL_WIDTH-1:0] arb_idx;
    logic                 xfer;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .req          (req),
        .ptr          (ptr_q),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx)
    );

    // Reset gates every combinational handshake so the sinks see reset values immediately.
    always_comb begin
        req           = snk_valid_i & snk_sop_i & port_en_i;
        xfer          = (state == XFER_S) && !srst_i;
        flush         = (state == ARB_S && !srst_i) ? (snk_valid_i & ~snk_sop_i & port_en_i) : '0;
        err_o         = |flush;
        src_data_o    = snk_data_i[int'(grant_q)*AST_DWIDTH +: AST_DWIDTH];
        src_empty_o   = snk_empty_i[int'(grant_q)*EMPTY_WIDTH +: EMPTY_WIDTH];
        src_channel_o = snk_channel_i[int'(grant_q)*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        src_sop_o     = snk_sop_i[grant_q];
        src_eop_o     = snk_eop_i[grant_q];
        src_valid_o   = xfer && snk_valid_i[grant_q];
        snk_ready_o   = flush;
        if (xfer) snk_ready_o[grant_q] = src_ready_i;
    end

    assign grant_o = grant_q;
    assign busy_o  = (state == XFER_S);

    // The pointer only moves on a completed EOP, so an aborted packet keeps its priority slot.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state   <= ARB_S;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            case (state)
                ARB_S: begin
                    if (|arb_onehot) begin
                        grant_q <= arb_idx;
                        state   <= XFER_S;
                    end
                end
                XFER_S: begin
                    if (src_valid_o && src_ready_i && src_eop_o) begin
                        ptr_q <= (grant_q == SEL_WIDTH'(NUM_SRC-1)) ? '0 : grant_q + 1'b1;
                        state <= ARB_S;
                    end
                end
                default: state <= ARB_S;
            endcase
        end
    end

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Directed bench for ast_packet_arbiter: per-port sink models feed packets, expected output
// words are queued in grant order at load time and a negedge monitor scores every beat.
module tb_ast_packet_arbiter;

    logic         clk = 1'b0;
    logic         srst;
    logic [255:0] snk_data;
    logic [11:0]  snk_empty;
    logic [3:0]   snk_channel;
    logic [3:0]   snk_sop;
    logic [3:0]   snk_eop;
    logic [3:0]   snk_valid;
    logic [3:0]   snk_ready;
    logic [63:0]  src_data;
    logic [2:0]   src_empty;
    logic [0:0]   src_channel;
    logic         src_sop;
    logic         src_eop;
    logic         src_valid;
    logic         src_ready;
    logic [3:0]   port_en;
    logic [1:0]   grant;
    logic         busy;
    logic         err;

    typedef struct packed {
        logic [63:0] data;
        logic [2:0]  empty;
        logic        channel;
        logic        sop;
        logic        eop;
    } word_t;

    typedef struct packed {
        logic [63:0] data;
        logic [2:0]  empty;
        logic        channel;
        logic        sop;
        logic        eop;
        logic [1:0]  port;
    } exp_t;

    word_t mem [4][64];
    int    head [4] = '{default: 0};
    int    tail [4] = '{default: 0};
    exp_t  sb_q [$];
    int    pop_cyc [512];
    int    pops = 0;
    int    cyc = 0;
    int    compared = 0;
    int    mismatched = 0;
    int    mark;

    ast_packet_arbiter #(.AST_DWIDTH(64), .CHANNEL_WIDTH(1), .NUM_SRC(4)) dut (
        .clk_i         (clk),
        .srst_i        (srst),
        .snk_data_i    (snk_data),
        .snk_empty_i   (snk_empty),
        .snk_channel_i (snk_channel),
        .snk_sop_i     (snk_sop),
        .snk_eop_i     (snk_eop),
        .snk_valid_i   (snk_valid),
        .snk_ready_o   (snk_ready),
        .src_data_o    (src_data),
        .src_empty_o   (src_empty),
        .src_channel_o (src_channel),
        .src_sop_o     (src_sop),
        .src_eop_o     (src_eop),
        .src_valid_o   (src_valid),
        .src_ready_i   (src_ready),
        .port_en_i     (port_en),
        .grant_o       (grant),
        .busy_o        (busy),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load_word(input int p, input word_t w);
        mem[p][tail[p]] = w;
        tail[p]++;
    endtask

    // Loads a packet on port p; only the first n_exp words are expected on the source.
    task automatic applyStimulus(input int p, input int pkt, input int len, input int n_exp);
        word_t w;
        exp_t  e;
        for (int i = 0; i < len; i++) begin
            w.data    = {16'(p), 16'(pkt), 16'hC0DE, 16'(i)};
            w.empty   = 3'(i + p);
            w.channel = 1'(p);
            w.sop     = (i == 0);
            w.eop     = (i == len - 1);
            load_word(p, w);
            if (i < n_exp) begin
                e = {w.data, w.empty, w.channel, w.sop, w.eop, 2'(p)};
                sb_q.push_back(e);
            end
        end
    endtask

    function automatic int pending();
        int s;
        s = sb_q.size();
        for (int p = 0; p < 4; p++) s += tail[p] - head[p];
        return s;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (pending() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 80'(pending()), 80'(0));
    endtask

    task automatic wait_size(input int lim);
        int n;
        n = 0;
        while (sb_q.size() > lim && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() > lim) checkOutput("wait_timeout", 80'(sb_q.size()), 80'(lim));
        #1;
    endtask

    // Sink models: consume on handshake at the edge, present the next word just after it.
    initial begin
        logic [3:0] fire;
        word_t      w;
        snk_valid = '0; snk_sop = '0; snk_eop = '0;
        snk_data = '0; snk_empty = '0; snk_channel = '0;
        forever begin
            @(posedge clk);
            fire = snk_valid & snk_ready;
            #1;
            for (int p = 0; p < 4; p++) begin
                if (fire[p]) head[p]++;
                if (head[p] < tail[p]) begin
                    w = mem[p][head[p]];
                    snk_valid[p] = 1'b1;
                    snk_data[p*64 +: 64] = w.data;
                    snk_empty[p*3 +: 3] = w.empty;
                    snk_channel[p] = w.channel;
                    snk_sop[p] = w.sop;
                    snk_eop[p] = w.eop;
                end else begin
                    snk_valid[p] = 1'b0;
                    snk_sop[p] = 1'b0;
                    snk_eop[p] = 1'b0;
                end
            end
        end
    end

    // Monitor: every valid beat is compared (stalled beats too), popped only on acceptance.
    initial begin
        exp_t act;
        forever begin
            @(negedge clk);
            cyc++;
            if (src_valid) begin
                act = {src_data, src_empty, src_channel, src_sop, src_eop, grant};
                if (sb_q.size() == 0) begin
                    if (src_ready) checkOutput("unexpected_word", 80'(act), 80'(0));
                end else begin
                    checkOutput("src_word", 80'(act), 80'(sb_q[0]));
                    if (src_ready) begin
                        void'(sb_q.pop_front());
                        pop_cyc[pops] = cyc;
                        pops++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        srst = 1'b1;
        port_en = 4'hF;
        src_ready = 1'b1;

        // Reset held with every sink offering a one-word packet.
        for (int p = 0; p < 4; p++) applyStimulus(p, 0, 1, 1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_state", 80'({src_valid, snk_ready, grant, busy, err}), 80'(0));
        end
        @(posedge clk);
        #1 srst = 1'b0;
        drain("drain_reset_order");

        // Single port 2 packet: one bubble, then granted.
        applyStimulus(2, 1, 3, 3);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t2_arb_bubble", 80'({busy, src_valid}), 80'(0));
        @(negedge clk);
        checkOutput("t2_grant", 80'({busy, src_valid, grant}), 80'({1'b1, 1'b1, 2'd2}));
        drain("drain_t2");

        // Pointer now 3: port 3 beats port 0.
        applyStimulus(3, 2, 1, 1);
        applyStimulus(0, 3, 1, 1);
        drain("drain_ptr3");

        // Four ports, two packets each, starting from pointer 1.
        mark = pops;
        for (int k = 0; k < 8; k++) applyStimulus((1 + k) % 4, 10 + k, 2, 2);
        drain("drain_t3");
        checkOutput("t3_cycles", 80'(pop_cyc[mark+15] - pop_cyc[mark]), 80'(22));

        // Valid without SOP while arbitrating is flushed with an error pulse.
        load_word(1, '{data: 64'hDEAD_BEEF_0000_0001, empty: 3'd0, channel: 1'b1, sop: 1'b0, eop: 1'b0});
        @(posedge clk);
        @(negedge clk);
        checkOutput("t4_flush", 80'({err, snk_ready, src_valid}), 80'({1'b1, 4'b0010, 1'b0}));
        @(negedge clk);
        checkOutput("t4_after_flush", 80'({err, snk_ready, src_valid}), 80'(0));
        drain("drain_t4");

        // Backpressure toggling on a port 3 packet.
        applyStimulus(3, 20, 4, 4);
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 7; i++) begin
            #1 src_ready = (i % 2 == 0);
            @(negedge clk);
            checkOutput("t5_snk_ready", 80'({busy, snk_ready}), 80'({1'b1, src_ready ? 4'b1000 : 4'b0000}));
            @(posedge clk);
        end
        #1 src_ready = 1'b1;
        drain("drain_t5");

        // Only ports 1 and 3 enabled; port 1 disabled mid-packet.
        port_en = 4'b1010;
        applyStimulus(1, 30, 3, 3);
        applyStimulus(3, 31, 3, 3);
        applyStimulus(1, 32, 3, 3);
        applyStimulus(3, 33, 3, 3);
        applyStimulus(0, 34, 2, 2);
        applyStimulus(1, 36, 2, 2);
        applyStimulus(2, 35, 2, 2);
        wait_size(11);
        port_en = 4'b1000;
        wait_size(6);
        repeat (2) begin
            @(negedge clk);
            checkOutput("t6_disabled_stall", 80'({busy, src_valid, snk_ready}), 80'(0));
        end
        port_en = 4'hF;
        drain("drain_t6");

        // Reset in the middle of a packet; the tail words are flushed afterwards.
        applyStimulus(2, 40, 4, 2);
        wait_size(0);
        srst = 1'b1;
        @(negedge clk);
        checkOutput("t7_reset_gate", 80'({src_valid, snk_ready, err}), 80'(0));
        @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        checkOutput("t7_tail_flush", 80'({busy, err, snk_ready}), 80'({1'b0, 1'b1, 4'b0100}));
        drain("drain_t7");
        checkOutput("t7_idle", 80'({busy, src_valid}), 80'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
